// File: rtl/freq_scan_pkg.sv
// Shared types and helpers for the frequency scan controller.
package freq_scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    GATE   = 3'd2,
    LATCH  = 3'd3,
    NEXT   = 3'd4
  } scan_state_t;

  localparam int DEF_CNT_W = 24;

  // Width of the channel pointer / channel index; never narrower than one bit.
  function automatic int ptr_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/freq_sync_edge.sv
// One-bit synchronizer followed by a rising-edge detector.
// rise is high for one clk when the synchronized input goes 0 -> 1.
module freq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Shift the asynchronous input through the sync chain and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/freq_scan_ctrl.sv
// Round-robin gated edge counter shared across NUM_CH asynchronous inputs.
// Each channel gets a settle period, a GATE_CYCLES counting window, a latch
// cycle and a pointer-advance cycle. Results feed the frequency PIO port.
// Optional build macro FREQ_SCAN_BANK_EN adds a per-channel result bank with
// a registered read port (rd_ch / rd_data = {overflow, count}).
//
// state  | meaning
// IDLE   | scanner stopped, waiting for enable
// SETTLE | SYNC_STAGES+1 cycles after a channel change, edges ignored
// GATE   | GATE_CYCLES cycles counting edges of the selected channel
// LATCH  | copy count/sat/pointer into the output registers
// NEXT   | advance channel pointer, continue or stop
module freq_scan_ctrl
  import freq_scan_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  localparam int PTR_W      = ptr_width(NUM_CH),
  localparam int TMR_W      = $clog2(GATE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] sig_in,
  output logic [CNT_W-1:0]  freq_out,
  output logic [PTR_W-1:0]  ch_out,
  output logic              freq_valid,
  output logic              overflow,
  output logic              busy
`ifdef FREQ_SCAN_BANK_EN
  ,
  input  logic [PTR_W-1:0]  rd_ch,
  output logic [CNT_W:0]    rd_data
`endif
);

  if (GATE_CYCLES < 1 || NUM_CH < 2 || NUM_CH > 16 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 3 || CNT_W < 1) begin : g_bad_cfg
    $error("freq_scan_ctrl: illegal parameter set");
  end

  localparam logic [1:0]       SETTLE_LAST = 2'(SYNC_STAGES);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(NUM_CH - 1);

  scan_state_t       state, state_nxt;
  logic [NUM_CH-1:0] rise_vec;
  logic              sel_rise;
  logic [PTR_W-1:0]  ptr;
  logic [1:0]        settle_cnt;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  count;
  logic              sat;
  logic              settle_done, gate_done;
  logic              in_settle, in_gate, in_latch, in_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    freq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (reset),
      .sig  (sig_in[g]),
      .rise (rise_vec[g])
    );
  end

  assign sel_rise    = rise_vec[ptr];
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign gate_done   = (timer == GATE_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; dropping enable aborts a settle or gate, but a latch always completes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE:  if (!enable) state_nxt = IDLE;
               else if (settle_done) state_nxt = GATE;
      GATE:    if (!enable) state_nxt = IDLE;
               else if (gate_done) state_nxt = LATCH;
      LATCH:   state_nxt = NEXT;
      NEXT:    state_nxt = enable ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control decode.
  always_comb begin
    busy      = (state != IDLE);
    in_settle = (state == SETTLE);
    in_gate   = (state == GATE);
    in_latch  = (state == LATCH);
    in_next   = (state == NEXT);
  end

  // Settle counter, gate timer, saturating edge counter and channel pointer.
  // Clearing timer/count/sat during SETTLE means GATE always starts from zero,
  // including after an aborted window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      timer      <= '0;
      count      <= '0;
      sat        <= 1'b0;
      ptr        <= '0;
    end else begin
      settle_cnt <= in_settle ? settle_cnt + 2'd1 : 2'd0;
      if (in_settle) begin
        timer <= '0;
        count <= '0;
        sat   <= 1'b0;
      end else if (in_gate) begin
        timer <= timer + TMR_W'(1);
        if (sel_rise) begin
          if (count == CNT_MAX) sat   <= 1'b1;
          else                  count <= count + CNT_W'(1);
        end
      end
      if (in_next) begin
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        sat <= 1'b0;
      end
    end
  end

  // Result registers; freq_valid pulses on the same edge that updates the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_out   <= '0;
      ch_out     <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= in_latch;
      if (in_latch) begin
        freq_out <= count;
        ch_out   <= ptr;
        overflow <= sat;
      end
    end
  end

`ifdef FREQ_SCAN_BANK_EN
  logic [CNT_W:0] bank [NUM_CH];

  // Per-channel result bank with a registered read port; a same-cycle write bypasses to the read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
      rd_data <= '0;
    end else begin
      if (in_latch) bank[ptr] <= {sat, count};
      if (in_latch && rd_ch == ptr)   rd_data <= {sat, count};
      else if (int'(rd_ch) < NUM_CH)  rd_data <= bank[rd_ch];
      else                            rd_data <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Self-checking bench for freq_scan_ctrl. The reference model records the
// per-cycle input history and predicts each report from the scan schedule:
// a run started in cycle e reports window k at e+(k+1)*P, counting input
// rises driven in cycles [e+k*P+2, e+k*P+GATE+1].
module tb_freq_scan_ctrl;

  localparam int NUM_CH  = 4;
  localparam int GATE    = 100;
  localparam int CNT_W   = 4;
  localparam int SYNC    = 2;
  localparam int P       = SYNC + 1 + GATE + 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MAX_CYC = 8192;

  logic              clk = 1'b0;
  logic              reset, enable;
  logic [NUM_CH-1:0] sig_in;
  logic [CNT_W-1:0]  freq_out;
  logic [1:0]        ch_out;
  logic              freq_valid, overflow, busy;
`ifdef FREQ_SCAN_BANK_EN
  logic [1:0]        rd_ch;
  logic [CNT_W:0]    rd_data;
`endif

  always #5 clk = ~clk;

  freq_scan_ctrl #(
    .NUM_CH(NUM_CH), .GATE_CYCLES(GATE), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sig_in     (sig_in),
    .freq_out   (freq_out),
    .ch_out     (ch_out),
    .freq_valid (freq_valid),
    .overflow   (overflow),
    .busy       (busy)
`ifdef FREQ_SCAN_BANK_EN
    ,
    .rd_ch      (rd_ch),
    .rd_data    (rd_data)
`endif
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic [NUM_CH-1:0] hist [MAX_CYC];

  bit running = 0;
  int run_start = 0, run_ch = 0, k_done = 0, stop_at = -1, resume_ch = 0;
  int exp_freq = 0, exp_ch = 0, exp_ovf = 0;
  int exp_bank [NUM_CH];
  int mode = 0;
  bit settle_step = 0;
  int dens [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int count_rises(input int ch, input int lo, input int hi);
    int n = 0;
    for (int t = lo; t <= hi; t++)
      if (hist[t][ch] && !hist[t-1][ch]) n++;
    return n;
  endfunction

  task automatic gen_sig();
    int rel, ch;
    case (mode)
      0: sig_in = {3'b000, 1'((cyc / 5) % 2)};
      1: sig_in = {1'b0, 1'(cyc % 2), 2'b00};
      2: for (int i = 0; i < NUM_CH; i++)
           if (int'($urandom_range(0, 15)) < dens[i]) sig_in[i] = ~sig_in[i];
      default: begin
        sig_in = '0;
        if (running && cyc >= run_start) begin
          rel = (cyc - run_start) % P;
          ch  = (run_ch + (cyc - run_start) / P) % NUM_CH;
          if (ch == 3) begin
            if (settle_step) sig_in[3] = (rel >= 1);
            else             sig_in[3] = ((rel >= 2 && rel <= 9) || rel >= GATE + 1);
          end
        end
      end
    endcase
  endtask

  task automatic step();
    int b, ch, n;
    bit ev;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAX_CYC - 1) begin
      n_fail++;
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAX_CYC - 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "cycle budget exhausted");
    end
    if (running && cyc == stop_at) running = 0;
    ev = running && (cyc == run_start + (k_done + 1) * P);
    if (ev) begin
      b  = run_start + k_done * P;
      ch = (run_ch + k_done) % NUM_CH;
      n  = count_rises(ch, b + 2, b + GATE + 1);
      exp_freq = (n > CNT_MAX) ? CNT_MAX : n;
      exp_ovf  = (n > CNT_MAX) ? 1 : 0;
      exp_ch   = ch;
      exp_bank[ch] = exp_ovf * (CNT_MAX + 1) + exp_freq;
      k_done++;
    end
    chk("freq_valid", freq_valid, ev);
    chk("freq_out", freq_out, exp_freq);
    chk("ch_out", ch_out, exp_ch);
    chk("overflow", overflow, exp_ovf);
    chk("busy", busy, (running && cyc > run_start) ? 1 : 0);
    gen_sig();
    hist[cyc] = sig_in;
  endtask

  task automatic start_run();
    enable    = 1'b1;
    running   = 1;
    run_start = cyc;
    run_ch    = resume_ch;
    k_done    = 0;
    stop_at   = -1;
  endtask

  task automatic stop_run();
    int rel;
    enable = 1'b0;
    rel = (cyc - run_start) - k_done * P;
    if (rel == P - 1) begin
      stop_at   = cyc + 2;
      resume_ch = (run_ch + k_done + 1) % NUM_CH;
    end else begin
      stop_at   = cyc + 1;
      resume_ch = (run_ch + k_done) % NUM_CH;
    end
  endtask

  task automatic wait_report();
    int t = 0;
    do begin
      step();
      t++;
    end while (!freq_valid && t < 2 * P + 10);
    chk("report_seen", freq_valid, 1);
  endtask

  task automatic run_to_rel(input int target);
    int t = 0, rel;
    do begin
      step();
      t++;
      rel = (cyc - run_start) - k_done * P;
    end while (rel != target && t < 2 * P);
    chk("window_pos", rel, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    running   = 0;
    exp_freq  = 0;
    exp_ch    = 0;
    exp_ovf   = 0;
    resume_ch = 0;
    foreach (exp_bank[i]) exp_bank[i] = 0;
    chk("rst_async_freq", freq_out, 0);
    chk("rst_async_ch", ch_out, 0);
    chk("rst_async_valid", freq_valid, 0);
    chk("rst_async_ovf", overflow, 0);
    chk("rst_async_busy", busy, 0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    int rst_rel;
    for (int i = 0; i < MAX_CYC; i++) hist[i] = '0;
    foreach (exp_bank[i]) exp_bank[i] = 0;
    foreach (dens[i]) dens[i] = 0;
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = '0;
`ifdef FREQ_SCAN_BANK_EN
    rd_ch  = '0;
`endif
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // ch0 toggles every 5 clk: 10 rises per window, idle channels report 0
    mode = 0;
    start_run();
    wait_report();
    chk("a_first_ch", ch_out, 0);
    chk("a_first_freq", freq_out, 10);
    chk("a_first_ovf", overflow, 0);
    repeat (3) begin
      wait_report();
      chk("a_idle_freq", freq_out, 0);
    end
    wait_report();
    chk("a_again_ch", ch_out, 0);
    chk("a_again_freq", freq_out, 10);

    // abort midway through the ch1 gate, then resume on ch1
    run_to_rel(SYNC + 2 + GATE / 2);
    stop_run();
    step();
    chk("abort_busy", busy, 0);
    chk("abort_keep_freq", freq_out, 10);
    repeat (10) step();
    start_run();
    wait_report();
    chk("resume_ch", ch_out, 1);

    // ch2 toggles every clk: saturation, then ch3 clean
    mode = 1;
    wait_report();
    chk("sat_ch", ch_out, 2);
    chk("sat_freq", freq_out, CNT_MAX);
    chk("sat_ovf", overflow, 1);
    wait_report();
    chk("after_sat_ovf", overflow, 0);

    // ch3 rises on first and last gate cycle, then a rise inside settle
    mode = 3;
    settle_step = 0;
    repeat (4) wait_report();
    chk("edge_bound_ch", ch_out, 3);
    chk("edge_bound_freq", freq_out, 2);
    settle_step = 1;
    repeat (4) wait_report();
    chk("edge_settle_ch", ch_out, 3);
    chk("edge_settle_freq", freq_out, 0);

    // random traffic; enable dropped during LATCH still delivers that result
    foreach (dens[i]) dens[i] = $urandom_range(0, 6);
    mode = 2;
    repeat (2) wait_report();
    run_to_rel(P - 1);
    stop_run();
    step();
    chk("latch_drop_valid", freq_valid, 1);
    step();
    chk("latch_drop_busy", busy, 0);
    repeat (5) step();
    start_run();
    repeat (5) wait_report();

    // reset mid-gate with enable held high
    foreach (dens[i]) dens[i] = $urandom_range(0, 6);
    run_to_rel(60);
    do_reset();
    start_run();
    rst_rel = cyc;
    wait_report();
    chk("rst_first_ch", ch_out, 0);
    chk("rst_latency", cyc - rst_rel, P);
    repeat (4) wait_report();

    run_to_rel(40);
    stop_run();
    repeat (5) step();
`ifdef FREQ_SCAN_BANK_EN
    for (int i = 0; i < NUM_CH; i++) begin
      rd_ch = 2'(i);
      step();
      chk("bank_rd", rd_data, exp_bank[i]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
